// File: rtl/vga_timing.sv
`timescale 1ns/1ps
// Video timing generator for the 1440x900 path: free-running h/v counters
// and a single register stage that aligns blanked colour, syncs and the frame tick.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1440,
  parameter int unsigned H_FP     = 80,
  parameter int unsigned H_SYNC   = 152,
  parameter int unsigned H_BP     = 232,
  parameter int unsigned V_ACTIVE = 900,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 28,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap;
  logic        act0;
  logic        hs0;
  logic        vs0;
  logic        tick0;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign draw_x = h_cnt;
  assign draw_y = v_cnt;

  // Stage-0 decode of the current counter position; registered below so every
  // output lines up with the colour returned for this draw_x/draw_y.
  always_comb begin
    act0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0   = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
    vs0   = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
    tick0 = (h_cnt == '0) && (v_cnt == V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      active     <= 1'b0;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      frame_tick <= 1'b0;
    end else begin
      vga_r      <= act0 ? r : '0;
      vga_g      <= act0 ? g : '0;
      vga_b      <= act0 ? b : '0;
      active     <= act0;
      hsync      <= hs0 ? HS_POL : ~HS_POL;
      vsync      <= vs0 ? VS_POL : ~VS_POL;
      frame_tick <= tick0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
// Bench for vga_timing: full-size instance for line-level timing, a shrunken
// instance for whole-frame timing and mid-frame reset, both against a reference model.
module tb_vga_timing;

  typedef struct packed {
    logic [11:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
    logic        tick;
  } exp_t;

  localparam exp_t RST_EXP = '{rgb: 12'h000, act: 1'b0, hs: 1'b1, vs: 1'b0, tick: 1'b0};

  // Shrunken geometry: 32 clocks per line, 18 lines per frame.
  localparam int SHA = 16, SHF = 4, SHW = 6, SHB = 6;
  localparam int SVA = 10, SVF = 1, SVW = 3, SVB = 4;
  localparam int SHT = SHA + SHF + SHW + SHB;
  localparam int SVT = SVA + SVF + SVW + SVB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d = 1'b0;
  logic        rst_s = 1'b0;
  logic        pix_mode = 1'b0;
  logic [11:0] pix_val = 12'hFFF;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  r_d, g_d, b_d, vr_d, vg_d, vb_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic        hs_d, vs_d, act_d, tick_d;
  logic [3:0]  r_s, g_s, b_s, vr_s, vg_s, vb_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic        hs_s, vs_s, act_s, tick_s;
  exp_t        got_d, got_s;

  assign {r_d, g_d, b_d} = pix_mode ? {x_d[3:0], x_d[7:4], 4'h5} : pix_val;
  assign {r_s, g_s, b_s} = pix_mode ? {x_s[3:0], x_s[7:4], 4'h5} : pix_val;
  assign got_d = {vr_d, vg_d, vb_d, act_d, hs_d, vs_d, tick_d};
  assign got_s = {vr_s, vg_s, vb_s, act_s, hs_s, vs_s, tick_s};

  vga_timing dut (
    .clk(clk), .rst_n(rst_d), .r(r_d), .g(g_d), .b(b_d),
    .draw_x(x_d), .draw_y(y_d), .vga_r(vr_d), .vga_g(vg_d), .vga_b(vb_d),
    .hsync(hs_d), .vsync(vs_d), .active(act_d), .frame_tick(tick_d)
  );

  vga_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHW), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVW), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .r(r_s), .g(g_s), .b(b_s),
    .draw_x(x_s), .draw_y(y_s), .vga_r(vr_s), .vga_g(vg_s), .vga_b(vb_s),
    .hsync(hs_s), .vsync(vs_s), .active(act_s), .frame_tick(tick_s)
  );

  function automatic logic [11:0] stim(input int h);
    logic [10:0] hv;
    hv = 11'(h);
    return pix_mode ? {hv[3:0], hv[7:4], 4'h5} : pix_val;
  endfunction

  function automatic exp_t model(input int h, input int v, input int ha, input int hf,
                                 input int hw, input int va, input int vf, input int vw,
                                 input logic [11:0] rgb);
    exp_t e;
    logic a;
    a      = (h < ha) && (v < va);
    e.rgb  = a ? rgb : 12'h000;
    e.act  = a;
    e.hs   = (h >= ha + hf && h < ha + hf + hw) ? 1'b0 : 1'b1;
    e.vs   = (v >= va + vf && v < va + vf + vw) ? 1'b1 : 1'b0;
    e.tick = (h == 0) && (v == va);
    return e;
  endfunction

  int   mh_d, mv_d, mh_s, mv_s;
  bit   en_d = 1'b0, en_s = 1'b0;
  exp_t sb_d[$];
  exp_t sb_s[$];

  always @(posedge clk or negedge rst_d) begin
    if (!rst_d) begin
      mh_d <= 0;
      mv_d <= 0;
    end else begin
      if (en_d) sb_d.push_back(model(mh_d, mv_d, 1440, 80, 152, 900, 1, 3, stim(mh_d)));
      mh_d <= (mh_d == 1903) ? 0 : mh_d + 1;
      if (mh_d == 1903) mv_d <= (mv_d == 931) ? 0 : mv_d + 1;
    end
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      mh_s <= 0;
      mv_s <= 0;
    end else begin
      if (en_s) sb_s.push_back(model(mh_s, mv_s, SHA, SHF, SHW, SVA, SVF, SVW, stim(mh_s)));
      mh_s <= (mh_s == SHT - 1) ? 0 : mh_s + 1;
      if (mh_s == SHT - 1) mv_s <= (mv_s == SVT - 1) ? 0 : mv_s + 1;
    end
  end

  task automatic test_reset();
    rst_d = 1'b0;
    rst_s = 1'b0;
    pix_mode = 1'b0;
    pix_val  = 12'hFFF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (x_d !== 11'd0 || y_d !== 10'd0) begin
      errors++;
      $display("FAIL reset_draw got=%0d,%0d exp=0,0", x_d, y_d);
    end
    checks++;
    if (got_d !== RST_EXP) begin
      errors++;
      $display("FAIL reset_outs got=%h exp=%h", got_d, RST_EXP);
    end
    checks++;
    if (got_s !== RST_EXP || x_s !== 11'd0 || y_s !== 10'd0) begin
      errors++;
      $display("FAIL reset_small got=%h/%0d/%0d exp=%h/0/0", got_s, x_s, y_s, RST_EXP);
    end
    rst_d = 1'b1;
    rst_s = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (x_d !== 11'd1 || y_d !== 10'd0 || x_s !== 11'd1) begin
      errors++;
      $display("FAIL first_edge got=%0d,%0d,%0d exp=1,0,1", x_d, y_d, x_s);
    end
    checks++;
    if (act_d !== 1'b1 || {vr_d, vg_d, vb_d} !== 12'hFFF) begin
      errors++;
      $display("FAIL first_pixel got=%b/%h exp=1/fff", act_d, {vr_d, vg_d, vb_d});
    end
  endtask

  task automatic test_passthrough();
    exp_t e;
    pix_mode = 1'b1;
    sb_d.delete();
    en_d = 1'b1;
    for (int k = 1; k < 1904; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb_d.size() == 0) begin
        errors++;
        $display("FAIL passthrough_sb k=%0d got=empty exp=entry", k);
        break;
      end
      e = sb_d.pop_front();
      if ({got_d, x_d, y_d} !== {e, 11'(mh_d), 10'(mv_d)}) begin
        errors++;
        $display("FAIL passthrough k=%0d got=%h exp=%h", k, {got_d, x_d, y_d},
                 {e, 11'(mh_d), 10'(mv_d)});
        break;
      end
      if (mh_d == 1440 || mh_d == 1441) begin
        checks++;
        if (vr_d !== ((mh_d == 1440) ? 4'hF : 4'h0)) begin
          errors++;
          $display("FAIL passthrough_edge h=%0d got=%h exp=%h", mh_d - 1, vr_d,
                   (mh_d == 1440) ? 4'hF : 4'h0);
        end
      end
    end
    en_d = 1'b0;
    pix_mode = 1'b0;
  endtask

  task automatic test_blanking();
    exp_t e;
    int   lit = 0;
    pix_val = 12'hFFF;
    sb_d.delete();
    en_d = 1'b1;
    for (int k = 0; k < 2 * 1904; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb_d.size() == 0) begin
        errors++;
        $display("FAIL blanking_sb k=%0d got=empty exp=entry", k);
        break;
      end
      e = sb_d.pop_front();
      if ({got_d, x_d, y_d} !== {e, 11'(mh_d), 10'(mv_d)}) begin
        errors++;
        $display("FAIL blanking k=%0d got=%h exp=%h", k, {got_d, x_d, y_d},
                 {e, 11'(mh_d), 10'(mv_d)});
        break;
      end
      if (act_d === 1'b1 && {vr_d, vg_d, vb_d} === 12'hFFF) lit++;
    end
    en_d = 1'b0;
    checks++;
    if (lit != 2 * 1440) begin
      errors++;
      $display("FAIL blanking_count got=%0d exp=%0d", lit, 2 * 1440);
    end
  endtask

  task automatic test_line_timing();
    int   n = 0;
    int   fall1 = -1, rise1 = -1, fall2 = -1;
    logic prev;
    while (!(mh_d == 0 && mv_d == 10) && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (x_d !== 11'd0 || y_d !== 10'd10) begin
      errors++;
      $display("FAIL line10_start got=%0d,%0d exp=0,10", x_d, y_d);
    end
    prev = hs_d;
    for (int k = 1; k <= 3500; k++) begin
      @(posedge clk); #1;
      if (prev === 1'b1 && hs_d === 1'b0) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      if (prev === 1'b0 && hs_d === 1'b1 && fall1 >= 0 && rise1 < 0) rise1 = k;
      prev = hs_d;
    end
    checks++;
    if (fall1 != 1521) begin
      errors++;
      $display("FAIL hsync_start got=%0d exp=1521", fall1);
    end
    checks++;
    if (rise1 - fall1 != 152) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=152", rise1 - fall1);
    end
    checks++;
    if (fall2 - fall1 != 1904) begin
      errors++;
      $display("FAIL hsync_period got=%0d exp=1904", fall2 - fall1);
    end
  endtask

  task automatic test_frame_timing();
    exp_t e;
    int   n = 0;
    int   tick1 = -1, tick2 = -1, nticks = 0, vrise = -1, vfall = -1;
    logic prev;
    pix_val = 12'hFFF;
    while (!(mh_s == 0 && mv_s == 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (x_s !== 11'd0 || y_s !== 10'd0) begin
      errors++;
      $display("FAIL frame_start got=%0d,%0d exp=0,0", x_s, y_s);
    end
    sb_s.delete();
    en_s = 1'b1;
    prev = vs_s;
    for (int k = 1; k <= 2 * SHT * SVT; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb_s.size() == 0) begin
        errors++;
        $display("FAIL frame_sb k=%0d got=empty exp=entry", k);
        break;
      end
      e = sb_s.pop_front();
      if ({got_s, x_s, y_s} !== {e, 11'(mh_s), 10'(mv_s)}) begin
        errors++;
        $display("FAIL frame k=%0d got=%h exp=%h", k, {got_s, x_s, y_s},
                 {e, 11'(mh_s), 10'(mv_s)});
        break;
      end
      if (tick_s === 1'b1) begin
        nticks++;
        if (tick1 < 0) tick1 = k;
        else if (tick2 < 0) tick2 = k;
      end
      if (prev === 1'b0 && vs_s === 1'b1 && vrise < 0) vrise = k;
      if (prev === 1'b1 && vs_s === 1'b0 && vrise >= 0 && vfall < 0) vfall = k;
      prev = vs_s;
    end
    en_s = 1'b0;
    checks++;
    if (tick1 != SVA * SHT + 1 || nticks != 2) begin
      errors++;
      $display("FAIL tick_pos got=%0d/%0d exp=%0d/2", tick1, nticks, SVA * SHT + 1);
    end
    checks++;
    if (tick2 - tick1 != SHT * SVT) begin
      errors++;
      $display("FAIL tick_period got=%0d exp=%0d", tick2 - tick1, SHT * SVT);
    end
    checks++;
    if (vrise != (SVA + SVF) * SHT + 1 || vfall - vrise != SVW * SHT) begin
      errors++;
      $display("FAIL vsync_pulse got=%0d/%0d exp=%0d/%0d", vrise, vfall - vrise,
               (SVA + SVF) * SHT + 1, SVW * SHT);
    end
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    int   n = 0;
    int   vrise = -1;
    logic prev;
    while (!(mv_s == SVA + SVF + 1 && mh_s == 5) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (vs_s !== 1'b1 || y_s !== 10'(SVA + SVF + 1)) begin
      errors++;
      $display("FAIL mid_pre got=%b/%0d exp=1/%0d", vs_s, y_s, SVA + SVF + 1);
    end
    #2;
    rst_s = 1'b0;
    #1;
    checks++;
    if (vs_s !== 1'b0 || y_s !== 10'd0 || x_s !== 11'd0) begin
      errors++;
      $display("FAIL mid_async got=%b/%0d/%0d exp=0/0/0", vs_s, y_s, x_s);
    end
    checks++;
    if (got_s !== RST_EXP) begin
      errors++;
      $display("FAIL mid_outs got=%h exp=%h", got_s, RST_EXP);
    end
    repeat (3) @(negedge clk);
    sb_s.delete();
    en_s = 1'b1;
    rst_s = 1'b1;
    prev = vs_s;
    for (int k = 1; k <= SHT * SVT; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sb_s.size() == 0) begin
        errors++;
        $display("FAIL mid_sb k=%0d got=empty exp=entry", k);
        break;
      end
      e = sb_s.pop_front();
      if ({got_s, x_s, y_s} !== {e, 11'(mh_s), 10'(mv_s)}) begin
        errors++;
        $display("FAIL mid_frame k=%0d got=%h exp=%h", k, {got_s, x_s, y_s},
                 {e, 11'(mh_s), 10'(mv_s)});
        break;
      end
      if (prev === 1'b0 && vs_s === 1'b1 && vrise < 0) vrise = k;
      prev = vs_s;
    end
    en_s = 1'b0;
    checks++;
    if (vrise != (SVA + SVF) * SHT + 1) begin
      errors++;
      $display("FAIL mid_vsync got=%0d exp=%0d", vrise, (SVA + SVF) * SHT + 1);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_blanking();
    test_line_timing();
    test_frame_timing();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Video timing generator and pixel output stage for the 1440x900 display path. It runs free-running horizontal and vertical counters and presents the current pixel coordinate on `draw_x`/`draw_y` to the combinational colour generator. It registers the returned `r`/`g`/`b`, blanks them outside the active area, and drives them to the VGA pins together with delay-matched `hsync`/`vsync`. It also issues a once-per-frame tick that game logic uses to update character and food positions during vertical blank.

## Interface
- `H_ACTIVE`, 1440, visible pixels per line
- `H_FP`, 80, horizontal front porch (clocks)
- `H_SYNC`, 152, horizontal sync width
- `H_BP`, 232, horizontal back porch
- `V_ACTIVE`, 900, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width
- `V_BP`, 28, vertical back porch
- `HS_POL`, 0, asserted level of `hsync`
- `VS_POL`, 1, asserted level of `vsync`
- `clk`  in  1  pixel clock, 106.47 MHz nominal; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `r`, `g`, `b`  in  4 each  colour from the pixel generator for the current `draw_x`/`draw_y`, combinational within the same cycle
- `draw_x`  out  11  current horizontal count
- `draw_y`  out  10  current vertical count
- `vga_r`, `vga_g`, `vga_b`  out  4 each  registered, blanked colour to the pins
- `hsync`, `vsync`  out  1 each  sync pulses at the parameter polarities
- `active`  out  1  high when the pixel on `vga_*` is visible
- `frame_tick`  out  1  one-clock pulse per frame at the start of vertical blank

## Operation
- `H_TOTAL` = sum of the H parameters (1904). `V_TOTAL` = sum of the V parameters (932).
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. On that wrap, `v_cnt` increments, wrapping from V_TOTAL-1 to 0. Both are registered.
- `draw_x = h_cnt` and `draw_y = v_cnt`, driven directly from the counter registers in all regions, including blanking.
- Stage-0 decode on the counters:
  - `act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`
  - `hs0` is true for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 1520..1671.
  - `vs0` is true for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 901..903, for the whole of each such line.
- Output register stage, applied every clock:
  - `vga_* <= act0 ? {r,g,b} : 0`
  - `active <= act0`
  - `hsync <= hs0 ? HS_POL : ~HS_POL`
  - `vsync <= vs0 ? VS_POL : ~VS_POL`
- `frame_tick <= (h_cnt == 0) && (v_cnt == V_ACTIVE)`
- No state machine beyond the counters. There is no handshake: the pixel generator must settle within one clock.
- Widths: `h_cnt` is 11 bits (max 1903), `v_cnt` is 10 bits (max 931). Compare in unsigned arithmetic only.

## Timing
- Reset (asynchronous assert, clean release on `clk`):
  - `h_cnt` = `v_cnt` = 0, so `draw_x` = `draw_y` = 0.
  - `vga_*` = 0, `active` = 0, `frame_tick` = 0.
  - `hsync` = ~HS_POL (1), `vsync` = ~VS_POL (0).
- First counter advance is on the first rising edge after `rst_n` rises.
- Reset asserted mid-frame forces all of the above immediately, with no wait for a clock edge. After release, scan restarts at (0,0) with no partial sync pulse.
- Latency: `draw_x`/`draw_y` to `vga_*`/`active`/`hsync`/`vsync`/`frame_tick` is exactly 1 clock. All outputs are aligned to the same pixel.
- Line = 1904 clocks. Frame = 1904 x 932 = 1,774,528 clocks.
- `frame_tick` is high for exactly one clock per frame. Updates made on it have 32 full lines before `v_cnt` returns to 0.
- `hsync` pulses on every line, including vblank lines.

## Test plan
- Reset release: hold `rst_n`=0 for 5 clocks, then release. Required: `draw_x`=0, `draw_y`=0, `vga_*`=0, `hsync`=1 and `vsync`=0 during reset; `draw_x`=1 after the first edge.
- Line timing: measure `hsync` on line 10. Required: low for 152 clocks starting exactly 1521 clocks after `draw_x`=0 (1520 plus 1 latency); period 1904 clocks.
- Frame timing: measure `vsync` and `frame_tick`. Required: `vsync` high for 3 x 1904 clocks starting 1 clock after `draw_y`=901,`draw_x`=0; `frame_tick` pulses once every 1,774,528 clocks, 1 clock after `draw_y`=900,`draw_x`=0.
- Blanking and alignment: hold `r`,`g`,`b`=F,F,F. Required:
  - `vga_*`=FFF with `active`=1 for the 1440 clocks following `draw_x`=0..1439 on lines 0..899.
  - `vga_*`=0 when `draw_x`=1440 (sampled next clock) and on all of lines 900..931.
- Pixel pass-through: drive `r`=`draw_x[3:0]` on line 0. Required: `vga_r` equals the previous cycle's `draw_x[3:0]` throughout the line, and 0 at the 1440 boundary.
- Mid-frame reset: assert `rst_n`=0 at `draw_y`=902 while `vsync` is asserted. Required: `vsync`=0 and `draw_y`=0 with no clock edge; after release, the first `vsync` pulse occurs at line 901 of the new frame.
